// File: rtl/clk_gen_pkg.sv
// Shared helpers for integer clock dividers: half-period calculation and counter sizing.
package clk_gen_pkg;

    // Half-period in source cycles, truncated and clamped to at least one cycle.
    function automatic int calc_half(input int main_hz, input int clk_hz);
        int h;
        if (clk_hz <= 0) begin
            return 1;
        end
        h = main_hz / (2 * clk_hz);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int ctr_width(input int half);
        int w;
        w = $clog2(half);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gen.sv
// Free-running 50 % duty-cycle clock divider; out_clk is driven directly from a flop.
// Optional simulation-only parameter and toggle checks are enabled with CLKGEN_CHECKS_EN.
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int   MAIN_CLK_HZ = 50_000_000,
    parameter int   CLK_HZ      = 10_000,
    parameter logic CLK_INIT    = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    output logic out_clk
);

    localparam int HALF  = calc_half(MAIN_CLK_HZ, CLK_HZ);
    localparam int CTR_W = ctr_width(HALF);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(HALF - 1);

    logic [CTR_W-1:0] ctr;

    // Toggle is registered on the same edge as terminal count, so no extra latency.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ctr     <= '0;
            out_clk <= CLK_INIT;
        end else if (ctr == CTR_LAST) begin
            ctr     <= '0;
            out_clk <= ~out_clk;
        end else begin
            ctr <= ctr + CTR_W'(1);
        end
    end

`ifdef CLKGEN_CHECKS_EN
    initial begin
        if (CLK_HZ == 0 || MAIN_CLK_HZ == 0) begin
            $error("clk_gen: zero frequency parameter (MAIN_CLK_HZ=%0d CLK_HZ=%0d)",
                   MAIN_CLK_HZ, CLK_HZ);
        end else begin
            if (MAIN_CLK_HZ / (2 * CLK_HZ) < 1) begin
                $warning("clk_gen: half-period clamped to 1, output runs at MAIN_CLK_HZ/2");
            end
            if (MAIN_CLK_HZ % (2 * CLK_HZ) != 0) begin
                $warning("clk_gen: non-integer ratio, output runs above CLK_HZ");
            end
        end
    end

    property p_toggle_at_terminal;
        @(posedge in_clk) disable iff (in_rst)
            (!$past(in_rst) && (out_clk != $past(out_clk))) |-> ($past(ctr) == CTR_LAST);
    endproperty
    a_toggle_at_terminal: assert property (p_toggle_at_terminal);
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen across several divide ratios, reset phases and the default configuration.
module tb_clk_gen;

    logic clk;
    logic rst;
    logic out_a, out_b, out_c, out_d, out_e, out_f;
    int   checks;
    int   errors;

    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b1)) u_a (.in_clk(clk), .in_rst(rst), .out_clk(out_a));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b0)) u_b (.in_clk(clk), .in_rst(rst), .out_clk(out_b));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(50), .CLK_INIT(1'b1)) u_c (.in_clk(clk), .in_rst(rst), .out_clk(out_c));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(80), .CLK_INIT(1'b1)) u_d (.in_clk(clk), .in_rst(rst), .out_clk(out_d));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(15), .CLK_INIT(1'b1)) u_e (.in_clk(clk), .in_rst(rst), .out_clk(out_e));
    clk_gen u_f (.in_clk(clk), .in_rst(rst), .out_clk(out_f));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level after n edges since reset release, for a given half-period.
    function automatic logic exp_lvl(input int n, input int half, input logic init);
        return init ^ logic'((n / half) % 2);
    endfunction

    task automatic check(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %b required %b", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        repeat (3) tick();
        check("rst_a", out_a, 1'b1);
        check("rst_b", out_b, 1'b0);
        check("rst_c", out_c, 1'b1);
        check("rst_d", out_d, 1'b1);
        check("rst_e", out_e, 1'b1);
        check("rst_f", out_f, 1'b1);

        rst = 1'b0;
        for (int n = 1; n <= 5000; n++) begin
            tick();
            if (n <= 200) begin
                check("div10_init1", out_a, exp_lvl(n, 5, 1'b1));
                check("div10_init0", out_b, exp_lvl(n, 5, 1'b0));
                check("clamp_50", out_c, exp_lvl(n, 1, 1'b1));
                check("clamp_80", out_d, exp_lvl(n, 1, 1'b1));
                check("nonint_15", out_e, exp_lvl(n, 3, 1'b1));
            end
            if (n == 1 || n == 2499 || n == 2500 || n == 4999 || n == 5000) begin
                check("default_half2500", out_f, exp_lvl(n, 2500, 1'b1));
            end
        end

        // Restart, then reset two cycles into the low phase of the HALF=5 divider.
        rst = 1'b1;
        tick();
        check("rerst_a", out_a, 1'b1);
        check("rerst_f", out_f, 1'b1);
        rst = 1'b0;
        repeat (7) tick();
        check("mid_low_a", out_a, 1'b0);
        check("mid_high_b", out_b, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_a", out_a, 1'b1);
        check("mid_rst_b", out_b, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check("after_mid_a", out_a, exp_lvl(n, 5, 1'b1));
            check("after_mid_b", out_b, exp_lvl(n, 5, 1'b0));
        end

        // Reset on the edge that would otherwise toggle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("pre_term_a", out_a, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_over_toggle_a", out_a, 1'b1);
        check("rst_over_toggle_b", out_b, 1'b0);
        check("rst_over_toggle_c", out_c, 1'b1);
        rst = 1'b0;
        tick();
        check("post_over_c", out_c, 1'b0);
        check("post_over_a", out_a, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
